// File: rtl/irq_encoder8to3.sv
// irq_encoder8to3: sticky 8-line IRQ capture (PEND) with ACK handshake presenting one encoded grant (Y, VALID) at a time; ports clk, rst_n, EN, D[7:0], ACK, Y[2:0], VALID, PEND[7:0]; define IRQ_ENCODER_RR_EN for round-robin, else fixed priority (bit 7 highest)
module irq_encoder8to3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic [7:0] D,
  input  logic       ACK,
  output logic [2:0] Y,
  output logic       VALID,
  output logic [7:0] PEND
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_n;
  logic [2:0] sel, y_n;
  logic [7:0] pend_n;
  logic ack_hit, grant;
  assign ack_hit = state == PRESENT && ACK;
  assign grant = state == IDLE && |PEND;
  assign VALID = state == PRESENT;
`ifdef IRQ_ENCODER_RR_EN
  logic [2:0] ptr;
  always_comb begin
    sel = ptr;
    for (int i = 8; i >= 1; i--)
      if (PEND[3'(ptr + 3'(i))]) sel = 3'(ptr + 3'(i));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 3'd7;
    else if (ack_hit) ptr <= Y;
`else
  always_comb begin
    sel = '0;
    for (int i = 0; i < 8; i++)
      if (PEND[i]) sel = 3'(i);
  end
`endif
  always_comb begin
    state_n = grant ? PRESENT : ack_hit ? IDLE : state;
    y_n = grant ? sel : Y;
    pend_n = (PEND & ~(ack_hit ? 8'd1 << Y : 8'h00)) | (EN ? D : 8'h00);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      Y <= '0;
      PEND <= '0;
    end else begin
      state <= state_n;
      Y <= y_n;
      PEND <= pend_n;
    end
endmodule

// File: tb/tb_irq_encoder8to3.sv
// tb_irq_encoder8to3: directed self-checking bench for irq_encoder8to3
module tb_irq_encoder8to3;
  logic clk = 0, rst_n = 0, en = 0, ack = 0;
  logic [7:0] d = 0;
  logic [2:0] y;
  logic valid;
  logic [7:0] pend;
  int checks = 0, failures = 0;
  irq_encoder8to3 dut (.clk(clk), .rst_n(rst_n), .EN(en), .D(d), .ACK(ack), .Y(y), .VALID(valid), .PEND(pend));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  task automatic pulse_reset;
    #2 rst_n = 0;
    #1;
    chk("rst_pend", pend, 8'h00);
    chk("rst_y", {5'd0, y}, 8'd0);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    #1 rst_n = 1;
  endtask
  task automatic wait_grant(input string tag, input logic [2:0] exp_y);
    int n = 0;
    while (!valid && n < 4) begin
      cyc();
      n++;
    end
    chk({tag, "_valid"}, {7'd0, valid}, 8'd1);
    chk({tag, "_y"}, {5'd0, y}, {5'd0, exp_y});
  endtask
  task automatic do_ack(input string tag);
    ack = 1;
    cyc();
    ack = 0;
    chk({tag, "_vlow"}, {7'd0, valid}, 8'd0);
  endtask
  logic [2:0] seq [4];
  initial begin
    #1;
    chk("rst0_pend", pend, 8'h00);
    chk("rst0_valid", {7'd0, valid}, 8'd0);
    chk("rst0_y", {5'd0, y}, 8'd0);
    cyc();
    rst_n = 1;
    en = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_valid", {7'd0, valid}, 8'd0);
      chk("idle_pend", pend, 8'h00);
      chk("idle_y", {5'd0, y}, 8'd0);
    end
    ack = 1;
    cyc();
    ack = 0;
    chk("ack_idle_pend", pend, 8'h00);
    chk("ack_idle_valid", {7'd0, valid}, 8'd0);
    d = 8'h20;
    cyc();
    d = 0;
    chk("pulse_pend", pend, 8'h20);
    chk("pulse_vlow", {7'd0, valid}, 8'd0);
    cyc();
    chk("pulse_valid", {7'd0, valid}, 8'd1);
    chk("pulse_y", {5'd0, y}, 8'd5);
    do_ack("pulse");
    chk("pulse_clr", pend, 8'h00);
    chk("pulse_yhold", {5'd0, y}, 8'd5);
`ifdef IRQ_ENCODER_RR_EN
    seq = '{3'd0, 3'd4, 3'd0, 3'd4};
    d = 8'h11;
    cyc();
    chk("rr_pend", pend, 8'h11);
    for (int i = 0; i < 4; i++) begin
      wait_grant("rr", seq[i]);
      do_ack("rr");
    end
    d = 0;
`else
    seq = '{3'd7, 3'd0, 3'd0, 3'd0};
    d = 8'h81;
    cyc();
    d = 0;
    chk("fp_pend", pend, 8'h81);
    for (int i = 0; i < 2; i++) begin
      wait_grant("fp", seq[i]);
      do_ack("fp");
    end
    chk("fp_clr", pend, 8'h00);
`endif
    pulse_reset();
    cyc();
    d = 8'h08;
    cyc();
    d = 0;
    chk("sc_pend", pend, 8'h08);
    cyc();
    chk("sc_valid", {7'd0, valid}, 8'd1);
    chk("sc_y", {5'd0, y}, 8'd3);
    d = 8'h08;
    do_ack("sc");
    d = 0;
    chk("sc_keep", pend, 8'h08);
    wait_grant("sc_regrant", 3'd3);
    do_ack("sc2");
    chk("sc_clr", pend, 8'h00);
    d = 8'hFF;
    cyc();
    en = 0;
    chk("ff_pend", pend, 8'hFF);
    cyc();
    chk("en0_valid", {7'd0, valid}, 8'd1);
`ifdef IRQ_ENCODER_RR_EN
    chk("en0_y", {5'd0, y}, 8'd4);
`else
    chk("en0_y", {5'd0, y}, 8'd7);
`endif
    cyc();
    chk("en0_hold", {7'd0, valid}, 8'd1);
    chk("en0_pend", pend, 8'hFF);
    pulse_reset();
    cyc();
    chk("post_rst_pend", pend, 8'h00);
    chk("post_rst_valid", {7'd0, valid}, 8'd0);
    d = 0;
    en = 1;
    cyc();
    chk("post_rst_idle", {7'd0, valid}, 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
